obf_drain: RTL and testbench

OBF_DRAIN -- requirements
Module: obf_drain

---
 rtl/obf_drain_pkg.sv | 31 +++
 rtl/obf_drain_skid.sv | 62 ++++++
 rtl/obf_drain.sv | 148 ++++++++++++++
 tb/tb_obf_drain.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/obf_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obf_drain_pkg
// Description : Shared accelerator definitions for the output-buffer drain:
//               drain FSM state encoding, skid depth and the clogb2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package obf_drain_pkg;

    // Drain controller states (2-bit explicit encoding)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } drain_state_e;

    // Number of entries in the read-data skid FIFO
    localparam int C_SKID_DEPTH = 2;

    // Ceiling log2; used to size buffer addresses from the buffer depth
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : obf_drain_pkg
`default_nettype wire

// File: rtl/obf_drain_skid.sv
`default_nettype none
// ============================================================================
// Module      : obf_drain_skid
// Description : Two-entry FIFO that catches buffer read data one cycle after
//               the read is issued and presents its head to the stream port.
//               The controller never pushes into a full FIFO without a pop,
//               so no overflow handling is needed here.
// Revision    : 1.0 - initial release
// ============================================================================
module obf_drain_skid #(
    parameter int WIDTH = 129
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       occ_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       occ_q;

    // Entry storage: write the pushed word at the write pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule : obf_drain_skid
`default_nettype wire

// File: rtl/obf_drain.sv
`default_nettype none
// ============================================================================
// Module      : obf_drain
// Description : Drains a contiguous (wrapping) range of the output buffer to
//               a valid/ready stream. Reads are issued only when the skid
//               FIFO is guaranteed room for the returning data, so read data
//               is never dropped and one word per cycle is sustained.
// Revision    : 1.0 - initial release
// ============================================================================
module obf_drain
    import obf_drain_pkg::*;
#(
    parameter int nb_pe_row      = 8,
    parameter int obf_width      = 16,
    parameter int obf_depth      = 8192,
    parameter int obf_addr_width = clogb2(obf_depth)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [obf_addr_width-1:0]         base_addr,
    input  logic [obf_addr_width:0]           nb_words,
    output logic [obf_addr_width-1:0]         obf_rAddr,
    output logic                              obf_rEn,
    input  logic [nb_pe_row*obf_width-1:0]    obf_out,
    output logic [nb_pe_row*obf_width-1:0]    out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done
);

    localparam int C_DW = nb_pe_row * obf_width;
    localparam int C_CW = obf_addr_width + 1;

    drain_state_e              state_q;
    logic [obf_addr_width-1:0] base_q;
    logic [C_CW-1:0]           nb_q;
    logic [C_CW-1:0]           issued_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      inflight_q;
    logic                      inflight_last_q;

    logic [1:0]                fifo_occ;
    logic [C_DW:0]             fifo_head;
    logic                      pop;
    logic                      rd_en;
    logic                      rd_last;
    logic [2:0]                slots_used;
    logic                      head_last;

    // Stream side: FIFO head carries the data plus its end-of-drain marker
    assign out_valid = (fifo_occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign head_last = fifo_head[C_DW];
    assign out_data  = fifo_head[C_DW-1:0];
    assign out_last  = out_valid && head_last;

    // Entries that will be occupied after this cycle if no new read is issued
    assign slots_used = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, pop};

    // Read issue: only while running, words remain, and the FIFO has room
    assign rd_en   = (state_q == ST_RUN) && (issued_q < nb_q) && (slots_used < 3'd2);
    assign rd_last = (issued_q == (nb_q - C_CW'(1)));

    // Address wraps naturally because obf_depth is a power of two
    assign obf_rAddr = base_q + issued_q[obf_addr_width-1:0];
    assign obf_rEn   = rd_en;

    assign busy = busy_q;
    assign done = done_q;

    // Drain FSM with registered busy/done and the issue counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            nb_q     <= '0;
            issued_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        nb_q     <= nb_words;
                        issued_q <= '0;
                        busy_q   <= 1'b1;
                        if (nb_words == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_en) begin
                        issued_q <= issued_q + C_CW'(1);
                    end
                    if (pop && head_last) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Track the read issued last cycle; its data is on obf_out this cycle.
    // Clearing on reset discards any data returning just after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en && rd_last;
        end
    end

    obf_drain_skid #(
        .WIDTH (C_DW + 1)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, obf_out}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .occ_o       (fifo_occ)
    );

endmodule : obf_drain
`default_nettype wire

// File: tb/tb_obf_drain.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_obf_drain
// Description : Self-checking bench for obf_drain. A buffer model returns a
//               deterministic word per address; a transaction-level model
//               predicts the address sequence, word stream, busy and done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obf_drain;

    localparam int NB_PE_ROW = 8;
    localparam int OBF_WIDTH = 16;
    localparam int OBF_DEPTH = 8192;
    localparam int AW        = 13;
    localparam int DW        = NB_PE_ROW * OBF_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   nb_words;
    logic [AW-1:0] obf_rAddr;
    logic          obf_rEn;
    logic [DW-1:0] obf_out;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    obf_drain #(
        .nb_pe_row (NB_PE_ROW),
        .obf_width (OBF_WIDTH),
        .obf_depth (OBF_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .nb_words  (nb_words),
        .obf_rAddr (obf_rAddr),
        .obf_rEn   (obf_rEn),
        .obf_out   (obf_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Deterministic buffer contents: every row differs, every address differs
    function automatic logic [DW-1:0] word_at(input int addr);
        logic [DW-1:0] w;
        for (int r = 0; r < NB_PE_ROW; r++) begin
            w[r*OBF_WIDTH +: OBF_WIDTH] = 16'((addr * 7 + r * 4099 + 23130) & 16'hffff);
        end
        return w;
    endfunction

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Buffer model: one-cycle read latency, garbage when not read
    always @(posedge clk) begin
        if (obf_rEn) obf_out <= word_at(int'(obf_rAddr));
        else         obf_out <= {$urandom, $urandom, $urandom, $urandom};
    end

    // ---------------- transaction-level reference model ----------------
    int            m_base, m_n, m_issued, m_popped, m_since;
    bit            m_busy, m_done;
    bit            ready_always;
    bit            prev_stall;
    bit            mon_pop;
    logic [DW-1:0] prev_data;

    // Samples on the falling edge; m_since counts rising edges after the
    // edge that accepted start (0 = right after that edge).
    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_issued = 0; m_popped = 0; m_n = 0;
            m_since = 0; prev_stall = 0;
        end else begin
            mon_pop = out_valid && out_ready;
            check_eq("busy", DW'(busy), DW'(m_busy));
            check_eq("done", DW'(done), DW'(m_done));
            if (!m_busy || m_done) check_eq("idle_valid", DW'(out_valid), '0);
            if (prev_stall) begin
                check_eq("stall_valid", DW'(out_valid), DW'(1));
                check_eq("stall_data", out_data, prev_data);
            end
            if (m_busy && !m_done && m_n != 0 && m_since == 1)
                check_eq("first_valid_early", DW'(out_valid), '0);
            if (m_busy && !m_done && m_n != 0 && m_since == 2)
                check_eq("first_valid_lat", DW'(out_valid), DW'(1));
            if (ready_always && m_busy && !m_done) begin
                if (m_since < m_n) check_eq("rd_rate", DW'(obf_rEn), DW'(1));
                if (m_since >= 2 && m_since < m_n + 2) check_eq("out_rate", DW'(out_valid), DW'(1));
            end
            if (obf_rEn) begin
                check_eq("rd_allowed", DW'(m_busy && !m_done && m_issued < m_n), DW'(1));
                check_eq("rd_addr", DW'(obf_rAddr), DW'((m_base + m_issued) % OBF_DEPTH));
                m_issued++;
            end
            check_eq("outstanding", DW'((m_issued - m_popped - int'(mon_pop)) <= 2), DW'(1));
            if (mon_pop) begin
                if (m_popped < m_n) begin
                    check_eq("data", out_data, word_at((m_base + m_popped) % OBF_DEPTH));
                    check_eq("last", DW'(out_last), DW'(m_popped == m_n - 1));
                end else begin
                    check_eq("extra_word", DW'(1), '0);
                end
                m_popped++;
            end
            // Predict the state after the next rising edge
            if (!m_busy) begin
                if (start) begin
                    m_base = int'(base_addr); m_n = int'(nb_words);
                    m_issued = 0; m_popped = 0; m_since = -1;
                    m_busy = 1; m_done = (nb_words == 0);
                end
            end else if (m_done) begin
                m_busy = 0; m_done = 0;
            end else if (mon_pop && m_popped == m_n) begin
                m_done = 1;
            end
            m_since++;
            prev_stall = out_valid && !out_ready && m_busy && !m_done;
            prev_data  = out_data;
        end
    end

    // mode: 0 = ready always high, 1 = ready low in cycles 3..7, 2 = random
    task automatic do_drain(input int base, input int n, input int mode, input bit poke);
        bit got;
        got = 0;
        ready_always = (mode == 0);
        @(posedge clk); #1;
        start = 1; base_addr = AW'(base); nb_words = (AW+1)'(n);
        out_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        for (int c = 1; c < 4 * n + 64; c++) begin
            @(posedge clk); #1;
            start = (poke && c == 3);
            base_addr = AW'($urandom); nb_words = (AW+1)'($urandom_range(1, 40));
            case (mode)
                1:       out_ready = !(c >= 3 && c <= 7);
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        check_eq("drain_completes", DW'(got), DW'(1));
        @(posedge clk); #1;
        start = 0; out_ready = 1; ready_always = 0;
    endtask

    initial begin
        rst = 1; start = 0; base_addr = '0; nb_words = '0; out_ready = 1;
        ready_always = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rEn", DW'(obf_rEn), '0);
        check_eq("rst_valid", DW'(out_valid), '0);
        check_eq("rst_busy", DW'(busy), '0);
        check_eq("rst_done", DW'(done), '0);
        check_eq("rst_data", out_data, '0);
        check_eq("rst_addr", DW'(obf_rAddr), '0);
        rst = 0;

        do_drain(0, 4, 0, 0);
        do_drain(8190, 4, 0, 0);
        do_drain(256, 6, 1, 0);
        do_drain(5, 0, 0, 0);

        // Reset in the middle of a 16-word drain
        @(posedge clk); #1;
        start = 1; base_addr = AW'(500); nb_words = (AW+1)'(16); ready_always = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (6) @(posedge clk);
        #3 rst = 1;
        #1;
        check_eq("mid_rst_rEn", DW'(obf_rEn), '0);
        check_eq("mid_rst_valid", DW'(out_valid), '0);
        check_eq("mid_rst_last", DW'(out_last), '0);
        check_eq("mid_rst_busy", DW'(busy), '0);
        check_eq("mid_rst_done", DW'(done), '0);
        check_eq("mid_rst_data", out_data, '0);
        check_eq("mid_rst_addr", DW'(obf_rAddr), '0);
        @(posedge clk); #1;
        rst = 0; ready_always = 0;
        do_drain(77, 8, 0, 0);

        // start pulsed while running must be ignored
        do_drain(33, 10, 0, 1);

        for (int i = 0; i < 25; i++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
            do_drain(int'($urandom_range(0, OBF_DEPTH - 1)), n, 2, (n >= 6) && $urandom_range(0, 1) == 1);
        end

        // Full-buffer drain, address wraps back to base
        do_drain(int'($urandom_range(0, OBF_DEPTH - 1)), OBF_DEPTH, 0, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_obf_drain
`default_nettype wire
